// File: rtl/pll_sup_pkg.sv
// Shared types, defaults and helper functions for the PLL lock supervisor.
package pll_sup_pkg;

   localparam int unsigned STATE_W = 3;

   // FSM encodings; values are visible on the debug state port.
   typedef enum logic [STATE_W-1:0] {
      ST_RESET_PLL = 3'd0,
      ST_ACQUIRE   = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } pll_state_e;

   // Default timing for a 25 MHz reference clock.
   localparam int unsigned REF_CLK_HZ         = 25_000_000;
   localparam int unsigned DEF_N_RST          = 4;
   localparam int unsigned DEF_PLL_RST_CYCLES = 16;
   localparam int unsigned DEF_ACQ_TIMEOUT    = REF_CLK_HZ / 1000;   // 1 ms
   localparam int unsigned DEF_STABLE_CYCLES  = REF_CLK_HZ / 10000;  // 100 us
   localparam int unsigned DEF_RST_STAGGER    = 8;
   localparam int unsigned DEF_MAX_RETRIES    = 3;
   localparam int unsigned DEF_CNT_W          = 8;

   // Ceiling log2; clog2(0) = clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Larger of two unsigned values, for width derivation.
   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_d;
   logic [W-1:0] meta_q;
   logic [W-1:0] sync_d;
   logic [W-1:0] sync_q;

   // Shift chain: input -> metastability flop -> output flop.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser flops, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL RST sequencing, lock qualification and staggered downstream reset release.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned N_RST          = DEF_N_RST,
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned ACQ_TIMEOUT    = DEF_ACQ_TIMEOUT,
   parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int unsigned RST_STAGGER    = DEF_RST_STAGGER,
   parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             pll_locked,
   input  logic             relock_req,
   output logic             pll_rst,
   output logic [N_RST-1:0] rst_n_out,
   output logic             ready,
   output logic             fault,
   output logic [CNT_W-1:0] loss_count,
   output logic [2:0]       state
);

   localparam int unsigned TMR_MAX = max2(max2(ACQ_TIMEOUT, STABLE_CYCLES),
                                          max2(PLL_RST_CYCLES, N_RST * RST_STAGGER));
   localparam int unsigned TMR_W   = max2(1, clog2(TMR_MAX));
   localparam int unsigned RETRY_W = max2(1, clog2(MAX_RETRIES + 1));

   // Last timer value of each timed phase.
   localparam logic [TMR_W-1:0]   T_RST_END    = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0]   T_ACQ_END    = TMR_W'(ACQ_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]   T_STABLE_END = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   T_REL_END    = TMR_W'((N_RST - 1) * RST_STAGGER);
   localparam logic [RETRY_W-1:0] R_MAX        = RETRY_W'(MAX_RETRIES);

   pll_state_e          state_d, state_q;
   logic [TMR_W-1:0]    tmr_d, tmr_q;
   logic [RETRY_W-1:0]  retry_d, retry_q;
   logic [CNT_W-1:0]    loss_d, loss_q;
   logic                pll_rst_d, pll_rst_q;
   logic [N_RST-1:0]    rst_n_out_d, rst_n_out_q;
   logic                ready_d, ready_q;
   logic                fault_d, fault_q;

   logic                lock_s;
   logic                lost_c;
   logic [N_RST-1:0]    rel_mask_c;

   // Bring the asynchronous PLL LOCK into the reference clock domain.
   sync2 #(
      .W (1)
   ) u_lock_sync (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Bits whose release slot has been reached for the upcoming timer value.
   for (genvar g = 0; g < N_RST; g++) begin : g_rel
      if (g == 0) begin : g_first
         assign rel_mask_c[g] = 1'b1;
      end else begin : g_rest
         assign rel_mask_c[g] = (tmr_d >= TMR_W'(g * RST_STAGGER));
      end
   end

   // Next state, retry/loss accounting and shared timer.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      tmr_d   = tmr_q;
      lost_c  = 1'b0;

      case (state_q)
         ST_RESET_PLL: begin
            if (tmr_q == T_RST_END) state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (tmr_q == T_ACQ_END) begin
               retry_d = retry_q + RETRY_W'(1);
               state_d = (retry_d == R_MAX) ? ST_FAULT : ST_RESET_PLL;
            end
         end
         ST_STABLE: begin
            // A dropout restarts acquisition without charging a retry.
            if (!lock_s)                    state_d = ST_ACQUIRE;
            else if (tmr_q == T_STABLE_END) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!lock_s)                 lost_c  = 1'b1;
            else if (tmr_q == T_REL_END) state_d = ST_RUN;
         end
         ST_RUN: begin
            retry_d = '0;
            if (!lock_s) lost_c = 1'b1;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_RESET_PLL;
         end
      endcase

      // Lock lost after qualification: count it and re-acquire from scratch.
      if (lost_c) begin
         state_d = ST_RESET_PLL;
         if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
      end

      // Software restart overrides everything, including a same-cycle loss.
      if (relock_req) begin
         state_d = ST_RESET_PLL;
         retry_d = '0;
         loss_d  = loss_q;
      end

      // Timer restarts on every state entry and saturates otherwise.
      if (relock_req || (state_d != state_q)) tmr_d = '0;
      else if (tmr_q != '1)                   tmr_d = tmr_q + TMR_W'(1);
   end

   // Output decode from the upcoming state so every output is registered.
   always_comb begin
      pll_rst_d   = 1'b0;
      rst_n_out_d = '0;
      ready_d     = 1'b0;
      fault_d     = 1'b0;
      case (state_d)
         ST_RESET_PLL: pll_rst_d = 1'b1;
         ST_RELEASE:   rst_n_out_d = rel_mask_c;
         ST_RUN: begin
            rst_n_out_d = '1;
            ready_d     = 1'b1;
         end
         ST_FAULT: begin
            pll_rst_d = 1'b1;
            fault_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q     <= ST_RESET_PLL;
         tmr_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_rst_q   <= 1'b1;
         rst_n_out_q <= '0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_rst_q   <= pll_rst_d;
         rst_n_out_q <= rst_n_out_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign rst_n_out  = rst_n_out_q;
   assign ready      = ready_q;
   assign fault      = fault_q;
   assign loss_count = loss_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// a negedge monitor pops and compares whenever the output vector changes.
module tb_pll_lock_supervisor;

   localparam int unsigned N_RST = 3;
   localparam int unsigned CNT_W = 2;

   logic             in_clk;
   logic             in_rst_n;
   logic             pll_locked;
   logic             relock_req;
   logic             pll_rst;
   logic [N_RST-1:0] rst_n_out;
   logic             ready;
   logic             fault;
   logic [CNT_W-1:0] loss_count;
   logic [2:0]       state;

   // Observed vector: {pll_rst, rst_n_out[2:0], ready, fault, loss_count[1:0], state[2:0]}
   typedef struct {
      int          cyc;   // negative: cycle not checked
      logic [10:0] v;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   logic [10:0] obs;
   logic [10:0] prev;
   bit          seen   = 1'b0;

   pll_lock_supervisor #(
      .N_RST          (3),
      .PLL_RST_CYCLES (4),
      .ACQ_TIMEOUT    (20),
      .STABLE_CYCLES  (10),
      .RST_STAGGER    (2),
      .MAX_RETRIES    (2),
      .CNT_W          (2)
   ) dut (
      .in_clk     (in_clk),
      .in_rst_n   (in_rst_n),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .rst_n_out  (rst_n_out),
      .ready      (ready),
      .fault      (fault),
      .loss_count (loss_count),
      .state      (state)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   always @(posedge in_clk) cyc <= cyc + 1;

   function automatic logic [10:0] pack(input logic pr, input logic [2:0] r, input logic rd,
                                        input logic f, input logic [1:0] l, input logic [2:0] s);
      return {pr, r, rd, f, l, s};
   endfunction

   task automatic push(input int c, input logic pr, input logic [2:0] r, input logic rd,
                       input logic f, input logic [1:0] l, input logic [2:0] s, input string tag);
      exp_t e;
      e.cyc = c;
      e.v   = pack(pr, r, rd, f, l, s);
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Lock already stable when ACQUIRE is entered at cycle x.
   task automatic push_reacq(input int x, input logic [1:0] l, input string tag);
      push(x + 1,  1'b0, 3'b000, 1'b0, 1'b0, l, 3'd2, {tag, "_stable"});
      push(x + 11, 1'b0, 3'b001, 1'b0, 1'b0, l, 3'd3, {tag, "_rel0"});
      push(x + 13, 1'b0, 3'b011, 1'b0, 1'b0, l, 3'd3, {tag, "_rel1"});
      push(x + 15, 1'b0, 3'b111, 1'b0, 1'b0, l, 3'd3, {tag, "_rel2"});
      push(x + 16, 1'b0, 3'b111, 1'b1, 1'b0, l, 3'd4, {tag, "_run"});
   endtask

   // Advance to 1 ns after the edge that makes cyc == c.
   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge in_clk);
         #1;
      end
   endtask

   // Monitor: every change of the output vector is matched against the queue head.
   always @(negedge in_clk) begin
      obs = {pll_rst, rst_n_out, ready, fault, loss_count, state};
      if (!seen || (obs != prev)) begin
         seen   = 1'b1;
         prev   = obs;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_change: got %b at cyc %0d, nothing expected", obs, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if ((obs !== mon_e.v) || ((mon_e.cyc >= 0) && (mon_e.cyc != cyc))) begin
               errors = errors + 1;
               $display("FAIL %s: got %b at cyc %0d, expected %b at cyc %0d",
                        mon_e.tag, obs, cyc, mon_e.v, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: no finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          b;
      int          c;
      logic [1:0]  l;
      logic [10:0] now_v;

      in_rst_n   = 1'b0;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      push(-1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "reset_state");
      at_cycle(3);

      // Nominal start: lock appears 6 cycles after reset release.
      b = cyc;
      in_rst_n = 1'b1;
      push(b + 4, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "nom_acquire");
      at_cycle(b + 6);
      pll_locked = 1'b1;
      push(b + 9,  1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd2, "nom_stable");
      push(b + 19, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 3'd3, "nom_rel0");
      push(b + 21, 1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 3'd3, "nom_rel1");
      push(b + 23, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 3'd3, "nom_rel2");
      push(b + 24, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 3'd4, "nom_run");
      at_cycle(b + 30);

      // relock_req together with a RUN loss, then lock never returns.
      c = cyc;
      pll_locked = 1'b0;
      push(c + 3,  1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "relock_beats_loss");
      push(c + 7,  1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "nolock_acq1");
      push(c + 27, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "nolock_retry1");
      push(c + 31, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "nolock_acq2");
      push(c + 51, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 3'd5, "nolock_fault");
      at_cycle(c + 2);
      relock_req = 1'b1;
      at_cycle(c + 3);
      relock_req = 1'b0;
      at_cycle(c + 60);

      // Exit FAULT; two more timeouts are needed before FAULT again.
      c = cyc;
      relock_req = 1'b1;
      push(c + 1,  1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "fault_exit");
      push(c + 5,  1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "fx_acq1");
      push(c + 25, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "fx_retry_cleared");
      push(c + 29, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "fx_acq2");
      push(c + 49, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 3'd5, "fx_fault_again");
      at_cycle(c + 1);
      relock_req = 1'b0;
      at_cycle(c + 55);

      // Exit FAULT with lock present and run up to RUN.
      c = cyc;
      relock_req = 1'b1;
      pll_locked = 1'b1;
      push(c + 1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "relock_rst");
      push(c + 5, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd1, "relock_acq");
      push_reacq(c + 5, 2'd0, "relock");
      at_cycle(c + 1);
      relock_req = 1'b0;
      at_cycle(c + 25);

      // Four one-cycle losses in RUN; the counter saturates at 3.
      for (int k = 1; k <= 4; k++) begin
         c = cyc;
         l = (k >= 3) ? 2'd3 : 2'(k);
         pll_locked = 1'b0;
         push(c + 3, 1'b1, 3'b000, 1'b0, 1'b0, l, 3'd0, "loss_reset");
         push(c + 7, 1'b0, 3'b000, 1'b0, 1'b0, l, 3'd1, "loss_acq");
         push_reacq(c + 7, l, "loss");
         at_cycle(c + 1);
         pll_locked = 1'b1;
         at_cycle(c + 26);
      end

      // Dropout in STABLE: back to ACQUIRE, no PLL reset, stable count restarts.
      c = cyc;
      pll_locked = 1'b0;
      push(c + 3,  1'b1, 3'b000, 1'b0, 1'b0, 2'd3, 3'd0, "flk_reset");
      push(c + 7,  1'b0, 3'b000, 1'b0, 1'b0, 2'd3, 3'd1, "flk_acq");
      push(c + 11, 1'b0, 3'b000, 1'b0, 1'b0, 2'd3, 3'd2, "flk_stable");
      push(c + 18, 1'b0, 3'b000, 1'b0, 1'b0, 2'd3, 3'd1, "flk_back_to_acq");
      push(c + 19, 1'b0, 3'b000, 1'b0, 1'b0, 2'd3, 3'd2, "flk_stable2");
      push(c + 29, 1'b0, 3'b001, 1'b0, 1'b0, 2'd3, 3'd3, "flk_rel0");
      push(c + 31, 1'b0, 3'b011, 1'b0, 1'b0, 2'd3, 3'd3, "flk_rel1");
      at_cycle(c + 8);
      pll_locked = 1'b1;
      at_cycle(c + 15);
      pll_locked = 1'b0;
      at_cycle(c + 16);
      pll_locked = 1'b1;

      // Asynchronous reset while rst_n_out = 011, mid-cycle.
      at_cycle(c + 31);
      @(negedge in_clk);
      #1;
      push(c + 32, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, "async_rst_held");
      in_rst_n = 1'b0;
      #1;
      now_v = {pll_rst, rst_n_out, ready, fault, loss_count, state};
      checks = checks + 1;
      if (now_v != pack(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0)) begin
         errors = errors + 1;
         $display("FAIL async_rst_immediate: got %b, expected %b", now_v,
                  pack(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0));
      end
      at_cycle(c + 40);

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL pending_expectations: %0d left, first %s expected at cyc %0d",
                  exp_q.size(), exp_q[0].tag, exp_q[0].cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
